// File: rtl/bs_digit_collector.sv
// bs_digit_collector
//   Digit-serial front end of the borrow-save to binary output path.
//   Collects W signed digits, most significant first, into a 2*W-bit
//   borrow-save word. The word is presented to the CSD-to-two's-complement
//   converter through a valid/ready handshake.
//
//   Optional build macro: BS_DIGIT_CANON_EN
//     defined     : an accepted digit 2'b11 (value 0) is stored as 2'b00
//     not defined : digits are stored exactly as received
//   The numeric value of the word is the same in both builds.
//
// Ports
//   clk        in   rising-edge clock
//   rst        in   synchronous active-high reset, takes effect even when ena=0
//   ena        in   clock enable; when low, all state and outputs hold
//   start      in   begin a new collection (clears the word and the counter)
//   dig_valid  in   upstream digit valid
//   dig        in   digit {s,d}, value = d - s
//   dig_ready  out  collector accepts a digit this cycle
//   out_valid  out  out_bs holds a complete word
//   out_ready  in   downstream accepts out_bs
//   out_bs     out  borrow-save word, digit i at [2i+1:2i] as {s,d}
//   busy       out  state is not IDLE
//
// State table
//   state       | meaning
//   ST_IDLE     | waiting for start, no word held
//   ST_COLLECT  | shifting in digits, dig_ready=1
//   ST_HOLD     | complete word on out_bs, out_valid=1 until handshake

module bs_digit_collector #(
  parameter int W     = 64,
  parameter int CNT_W = $clog2(W + 1)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           ena,
  input  logic           start,
  input  logic           dig_valid,
  input  logic [1:0]     dig,
  output logic           dig_ready,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*W-1:0] out_bs,
  output logic           busy
);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_COLLECT = 2'd1;
  localparam logic [1:0] ST_HOLD    = 2'd2;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(W - 1);

  logic [1:0]     state;
  logic [2*W-1:0] shreg;
  logic [CNT_W-1:0] cnt;
  logic [1:0]     dig_store;
  logic           accept;

`ifdef BS_DIGIT_CANON_EN
  // {1,1} and {0,0} both mean zero; fold to the single canonical form.
  assign dig_store = (dig == 2'b11) ? 2'b00 : dig;
`else
  assign dig_store = dig;
`endif

  // Outputs come straight from registered state; no input reaches an output
  // combinationally.
  assign dig_ready = (state == ST_COLLECT);
  assign out_valid = (state == ST_HOLD);
  assign busy      = (state != ST_IDLE);
  assign out_bs    = shreg;

  assign accept = dig_valid & dig_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      shreg <= '0;
      cnt   <= '0;
    end else if (ena) begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            state <= ST_COLLECT;
            shreg <= '0;
            cnt   <= '0;
          end
        end
        ST_COLLECT: begin
          // A restart wins over a digit offered in the same cycle; that
          // digit is dropped.
          if (start) begin
            shreg <= '0;
            cnt   <= '0;
          end else if (accept) begin
            shreg <= {shreg[2*W-3:0], dig_store};
            cnt   <= cnt + CNT_W'(1);
            if (cnt == CNT_LAST) begin
              state <= ST_HOLD;
            end
          end
        end
        ST_HOLD: begin
          // start without out_ready is ignored so the held word is never
          // lost; start with out_ready chains straight into a new word.
          if (out_ready) begin
            if (start) begin
              state <= ST_COLLECT;
              shreg <= '0;
              cnt   <= '0;
            end else begin
              state <= ST_IDLE;
            end
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bs_digit_collector.sv
// tb_bs_digit_collector
//   Self-checking bench for bs_digit_collector with W=4. Expected words are
//   pushed to a scoreboard queue as stimulus is driven and compared when the
//   DUT completes a valid/ready handshake. Direct checks cover reset state,
//   latency, hold behaviour, restart, clock enable and reset mid-collection.

module tb_bs_digit_collector;

  localparam int W = 4;

  logic           clk;
  logic           rst;
  logic           ena;
  logic           start;
  logic           dig_valid;
  logic [1:0]     dig;
  logic           dig_ready;
  logic           out_valid;
  logic           out_ready;
  logic [2*W-1:0] out_bs;
  logic           busy;

  int n_checks = 0;
  int n_fail   = 0;

  logic [2*W-1:0] sb_q[$];

  bs_digit_collector #(.W(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .ena       (ena),
    .start     (start),
    .dig_valid (dig_valid),
    .dig       (dig),
    .dig_ready (dig_ready),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_bs    (out_bs),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Stored encoding of a word as the collector would hold it.
  function automatic logic [2*W-1:0] stored(input logic [2*W-1:0] w);
    logic [2*W-1:0] r;
    r = w;
`ifdef BS_DIGIT_CANON_EN
    for (int i = 0; i < W; i++) begin
      if (r[2*i +: 2] == 2'b11) r[2*i +: 2] = 2'b00;
    end
`endif
    return r;
  endfunction

  // Numeric value of a borrow-save word modulo 2^W (converter output).
  function automatic logic [63:0] bs_val(input logic [2*W-1:0] w);
    int v;
    v = 0;
    for (int i = 0; i < W; i++) begin
      v = v + (int'(w[2*i]) - int'(w[2*i+1])) * (1 << i);
    end
    return 64'(v & ((1 << W) - 1));
  endfunction

  // Advance one cycle; inputs and checks happen 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Optionally start, then drive the W digits of w (MSD at top) back-to-back.
  task automatic collect(input logic [2*W-1:0] w, input bit do_start, input string tag);
    if (do_start) begin
      start = 1'b1;
      step();
      start = 1'b0;
      chk({tag, "_ready_after_start"}, 64'(dig_ready), 64'd1);
    end
    for (int i = W - 1; i >= 0; i--) begin
      dig_valid = 1'b1;
      dig       = w[2*i +: 2];
      if (i == 0) sb_q.push_back(stored(w));
      step();
      chk({tag, "_valid_latency"}, 64'(out_valid), (i == 0) ? 64'd1 : 64'd0);
    end
    dig_valid = 1'b0;
    dig       = 2'b00;
  endtask

  // Scoreboard: compare at every accepted handshake.
  always @(negedge clk) begin
    if (!rst && ena && out_valid && out_ready) begin
      if (sb_q.size() == 0) begin
        chk("sb_unexpected_word", 64'(out_bs), 64'hDEAD);
      end else begin
        logic [2*W-1:0] e;
        e = sb_q.pop_front();
        chk("sb_word", 64'(out_bs), 64'(e));
        chk("sb_value", bs_val(out_bs), bs_val(e));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; ena = 1'b1; start = 1'b0; dig_valid = 1'b0; dig = 2'b00; out_ready = 1'b0;
    step();
    step();
    rst = 1'b0;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_dig_ready", 64'(dig_ready), 64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_bs", 64'(out_bs), 64'd0);
    step();
    chk("idle_stays", 64'(busy), 64'd0);

    // Test 1: basic word, handshake immediately.
    out_ready = 1'b1;
    collect(8'b01_00_10_01, 1'b1, "t1");
    chk("t1_word", 64'(out_bs), 64'h49);
    chk("t1_value", bs_val(out_bs), 64'd7);
    step();
    chk("t1_idle_valid", 64'(out_valid), 64'd0);
    chk("t1_idle_busy", 64'(busy), 64'd0);

    // Test 2: downstream stalls for 5 cycles; a lone start is ignored.
    out_ready = 1'b0;
    collect(8'b01_00_10_01, 1'b1, "t2");
    for (int k = 0; k < 5; k++) begin
      start = (k == 2);
      step();
      chk("t2_hold_valid", 64'(out_valid), 64'd1);
      chk("t2_hold_word", 64'(out_bs), 64'h49);
    end
    start = 1'b0;
    out_ready = 1'b1;
    step();
    chk("t2_after_valid", 64'(out_valid), 64'd0);
    chk("t2_after_busy", 64'(busy), 64'd0);

    // Test 3: restart mid-collection drops the digit offered with start.
    start = 1'b1;
    step();
    start = 1'b0;
    dig_valid = 1'b1; dig = 2'b01; step();
    dig_valid = 1'b1; dig = 2'b01; step();
    chk("t3_cnt_before", 64'(dut.cnt), 64'd2);
    start = 1'b1; dig_valid = 1'b1; dig = 2'b10;
    step();
    start = 1'b0;
    chk("t3_cnt_restart", 64'(dut.cnt), 64'd0);
    chk("t3_bs_restart", 64'(out_bs), 64'd0);
    collect(8'b10_10_10_10, 1'b0, "t3");
    chk("t3_word", 64'(out_bs), 64'hAA);
    chk("t3_value", bs_val(out_bs), 64'd1);
    step();

    // Test 4: all-zero digits in the 11 encoding.
    collect(8'b11_11_11_11, 1'b1, "t4");
`ifdef BS_DIGIT_CANON_EN
    chk("t4_word", 64'(out_bs), 64'h00);
`else
    chk("t4_word", 64'(out_bs), 64'hFF);
`endif
    chk("t4_value", bs_val(out_bs), 64'd0);
    step();

    // Test 5: ena low for 3 cycles after digit 2 with a digit on offer.
    start = 1'b1; step(); start = 1'b0;
    dig_valid = 1'b1; dig = 2'b01; step();
    dig_valid = 1'b1; dig = 2'b00; step();
    ena = 1'b0;
    dig_valid = 1'b1; dig = 2'b10;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("t5_cnt_frozen", 64'(dut.cnt), 64'd2);
      chk("t5_bs_frozen", 64'(out_bs), 64'h04);
    end
    ena = 1'b1;
    dig_valid = 1'b1; dig = 2'b10; step();
    chk("t5_valid_early", 64'(out_valid), 64'd0);
    sb_q.push_back(stored(8'h49));
    dig_valid = 1'b1; dig = 2'b01; step();
    dig_valid = 1'b0;
    chk("t5_valid", 64'(out_valid), 64'd1);
    chk("t5_word", 64'(out_bs), 64'h49);
    step();

    // Test 6: reset after 3 accepted digits discards the partial word.
    start = 1'b1; step(); start = 1'b0;
    dig_valid = 1'b1; dig = 2'b01; step();
    dig_valid = 1'b1; dig = 2'b10; step();
    dig_valid = 1'b1; dig = 2'b01; step();
    dig_valid = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("t6_busy", 64'(busy), 64'd0);
    chk("t6_dig_ready", 64'(dig_ready), 64'd0);
    chk("t6_out_bs", 64'(out_bs), 64'd0);
    collect(8'b01_01_10_00, 1'b1, "t6");
    chk("t6_value", bs_val(out_bs), 64'd10);
    step();

    // Test 7: handshake together with start goes straight to COLLECT.
    out_ready = 1'b0;
    collect(8'b10_00_01_11, 1'b1, "t7a");
    out_ready = 1'b1; start = 1'b1;
    step();
    start = 1'b0;
    chk("t7_dig_ready", 64'(dig_ready), 64'd1);
    chk("t7_busy", 64'(busy), 64'd1);
    chk("t7_out_valid", 64'(out_valid), 64'd0);
    chk("t7_cnt", 64'(dut.cnt), 64'd0);
    collect(8'b00_01_01_10, 1'b0, "t7b");
    step();
    step();

    chk("sb_drained", 64'(sb_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
